radius_sched: RTL and testbench

RADIUS_SCHED -- requirements
Module: radius_sched

---
 rtl/radius_sched.sv | 173 +++++++++++++++++
 tb/tb_radius_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radius_sched.sv
// -----------------------------------------------------------------------------
// radius_sched
//   Two-requester front end for a squared-radius calculator. Each requester
//   presents a signed 10-bit (x, y) screen-relative pair. One pair at a time is
//   granted round-robin. Both coordinates are folded to 7-bit magnitudes and
//   squared one after the other on a single shared 7x7 squarer. The result
//   (x^2 + y^2) >> SHIFT is then held on a valid/ready output until consumed.
//
//   Sequence: IDLE -> SQX -> SQY -> OUT -> IDLE. A pair accepted at edge T is
//   presented with out_valid from the cycle ending at edge T+3.
//
// Parameters
//   SHIFT       right shift applied to the 15-bit sum of squares
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous, active-high reset
//   req0_valid  requester 0 has a pair pending
//   req0_x/y    requester 0 signed coordinates (10 bits)
//   req0_ready  requester 0's pair is accepted this cycle
//   req1_*      same for requester 1
//   out_valid   result available
//   out_ready   consumer accepts the result
//   out_rsq     (x^2 + y^2) >> SHIFT, zero-extended to 15 bits
//   out_id      requester that owns out_rsq
//   busy        high whenever the scheduler is not in IDLE
// -----------------------------------------------------------------------------
module radius_sched #(
    parameter int SHIFT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [9:0]  req0_x,
    input  logic [9:0]  req0_y,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [9:0]  req1_x,
    input  logic [9:0]  req1_y,
    output logic        req1_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_rsq,
    output logic        out_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQX  = 2'd1,
        SQY  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        last_grant;  // requester granted most recently
    logic        grant_any;   // a pair is accepted on the coming edge
    logic        grant_id;    // which requester is accepted
    logic        id;          // owner of the pair in flight
    logic [6:0]  sq_op;       // squarer operand: norm_x in SQX, norm_y in SQY
    logic [6:0]  norm_y;      // norm_y parked until SQX completes
    logic [13:0] sq_prod;
    logic [13:0] x_sq;
    logic [13:0] y_sq;
    logic [14:0] sum_sq;

    // Fold a signed coordinate into a 7-bit magnitude. Negative values take
    // the one's complement of bits [8:2], so -1 and 0 both map to 0 and
    // the result never needs an extra bit.
    function automatic logic [6:0] fold(input logic [9:0] pos);
        return pos[9] ? ~pos[8:2] : pos[8:2];
    endfunction

    logic [6:0] norm0_x, norm0_y, norm1_x, norm1_y;
    assign norm0_x = fold(req0_x);
    assign norm0_y = fold(req0_y);
    assign norm1_x = fold(req1_x);
    assign norm1_y = fold(req1_y);

    // The two LSBs of every coordinate fall below the folding resolution.
    logic unused_lsbs;
    assign unused_lsbs = ^{req0_x[1:0], req0_y[1:0], req1_x[1:0], req1_y[1:0]};

    // The single shared squarer. Operands are zero-extended so the full
    // 14-bit product is kept.
    assign sq_prod = {7'd0, sq_op} * {7'd0, sq_op};

    // Full-width sum: 2 * 127^2 = 32258 fits in 15 bits.
    assign sum_sq = {1'b0, x_sq} + {1'b0, y_sq};

    // ------------------------------------------------------------------
    // Next-state, arbitration and handshake outputs
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        grant_any  = 1'b0;
        grant_id   = last_grant;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state)
            IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    grant_any = 1'b1;
                    // On a tie, the requester not granted last time wins.
                    if (req0_valid && req1_valid)
                        grant_id = ~last_grant;
                    else
                        grant_id = req1_valid;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_next = SQX;
                end
            end
            SQX:     state_next = SQY;
            SQY:     state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // last_grant starts at requester 1 so requester 0 wins the
            // first tie.
            state      <= IDLE;
            last_grant <= 1'b1;
            id         <= 1'b0;
            sq_op      <= '0;
            norm_y     <= '0;
            x_sq       <= '0;
            y_sq       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_id;
                        id         <= grant_id;
                        sq_op      <= grant_id ? norm1_x : norm0_x;
                        norm_y     <= grant_id ? norm1_y : norm0_y;
                    end
                end
                SQX: begin
                    x_sq  <= sq_prod;
                    sq_op <= norm_y;
                end
                SQY: begin
                    y_sq <= sq_prod;
                end
                default: ;
            endcase
        end
    end

    // Result registers only change in SQX/SQY, so the outputs are steady for
    // the whole of OUT, including the cycle out_valid rises. While rst is
    // high they are forced low straight away rather than after the edge.
    assign out_valid = !rst && (state == OUT);
    assign busy      = !rst && (state != IDLE);
    assign out_rsq   = rst ? 15'd0 : (sum_sq >> SHIFT);
    assign out_id    = !rst && id;

endmodule

// File: tb/tb_radius_sched.sv
// -----------------------------------------------------------------------------
// tb_radius_sched
//   Self-checking bench for radius_sched. Stimulus changes on the falling
//   edge. Outputs are sampled 1 time unit later, well away from the rising
//   edge. Expected results come from a transaction-level model: integer
//   folding of the signed coordinates, a plain round-robin rule, and fixed
//   latency.
// -----------------------------------------------------------------------------
module tb_radius_sched;

    localparam int SHIFT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [9:0]  req0_x, req0_y, req1_x, req1_y;
    logic        req0_ready, req1_ready;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_rsq;
    logic        out_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic m_last;  // model: requester granted most recently

    radius_sched #(.SHIFT(SHIFT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rsq    (out_rsq),
        .out_id     (out_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Magnitude of a signed coordinate at 1/4 resolution. For negative v the
    // folded value is (-v - 1) / 4.
    function automatic int norm_of(input logic [9:0] p);
        int v;
        v = $signed(p);
        if (v < 0) return (-v - 1) / 4;
        return v / 4;
    endfunction

    function automatic logic [14:0] model_rsq(input logic [9:0] x, input logic [9:0] y);
        int nx, ny, s;
        nx = norm_of(x);
        ny = norm_of(y);
        s  = nx * nx + ny * ny;
        return 15'(s / (1 << SHIFT));
    endfunction

    // Round-robin rule: a lone requester wins; on a tie the one not granted
    // last time wins.
    function automatic logic model_grant(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return (last == 1'b0);
        return v1;
    endfunction

    task automatic drive_busy_inputs(input bit keep_valid);
        req0_valid = keep_valid ? 1'b1 : 1'($urandom);
        req1_valid = keep_valid ? 1'b1 : 1'($urandom);
        req0_x = 10'($urandom);
        req0_y = 10'($urandom);
        req1_x = 10'($urandom);
        req1_y = 10'($urandom);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
    endtask

    // One complete transaction, starting at a falling edge with the DUT
    // idle. It checks the grant, the quiet SQX/SQY cycles, the result, the
    // hold under stall, and the return to idle. The caller must drive at
    // least one valid.
    task automatic do_txn(input string tag, input logic v0, input logic v1,
                          input logic [9:0] x0, input logic [9:0] y0,
                          input logic [9:0] x1, input logic [9:0] y1,
                          input int stall, input bit keep_valid,
                          output logic [14:0] got_rsq, output logic got_id);
        logic        exp_id;
        logic [14:0] exp_rsq;
        logic        nxt;
        exp_id  = model_grant(v0, v1, m_last);
        exp_rsq = exp_id ? model_rsq(x1, y1) : model_rsq(x0, y0);
        req0_valid = v0; req0_x = x0; req0_y = y0;
        req1_valid = v1; req1_x = x1; req1_y = y1;
        out_ready  = 1'($urandom);
        #1;
        n_checks++;
        if ({req1_ready, req0_ready} !== {exp_id, ~exp_id}) begin
            n_fail++;
            $display("FAIL %s grant: readies(1,0)=%b%b expected %b%b", tag,
                     req1_ready, req0_ready, exp_id, ~exp_id);
        end
        m_last = exp_id;

        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            drive_busy_inputs(keep_valid);
            out_ready = 1'($urandom);
            #1;
            n_checks++;
            if ({out_valid, busy, req0_ready, req1_ready} !== 4'b0100) begin
                n_fail++;
                $display("FAIL %s compute%0d: valid=%b busy=%b rdy=%b%b expected valid=0 busy=1 rdy=00",
                         tag, c, out_valid, busy, req0_ready, req1_ready);
            end
        end

        @(negedge clk);
        drive_busy_inputs(keep_valid);
        out_ready = (stall == 0);
        #1;
        got_rsq = out_rsq;
        got_id  = out_id;
        n_checks++;
        if ({out_valid, busy} !== 2'b11 || out_rsq !== exp_rsq || out_id !== exp_id) begin
            n_fail++;
            $display("FAIL %s result: valid=%b busy=%b rsq=%0d id=%b expected valid=1 busy=1 rsq=%0d id=%b",
                     tag, out_valid, busy, out_rsq, out_id, exp_rsq, exp_id);
        end

        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            drive_busy_inputs(keep_valid);
            out_ready = (s == stall);
            #1;
            n_checks++;
            if ({out_valid, busy, req0_ready, req1_ready} !== 4'b1100 ||
                out_rsq !== exp_rsq || out_id !== exp_id) begin
                n_fail++;
                $display("FAIL %s stall%0d: valid=%b busy=%b rdy=%b%b rsq=%0d id=%b expected 1 1 00 rsq=%0d id=%b",
                         tag, s, out_valid, busy, req0_ready, req1_ready, out_rsq, out_id, exp_rsq, exp_id);
            end
        end

        // Handshake edge has passed: idle again, and any valid requester is
        // offered a grant straight away.
        @(negedge clk);
        drive_busy_inputs(keep_valid);
        out_ready = 1'b0;
        #1;
        nxt = model_grant(req0_valid, req1_valid, m_last);
        n_checks++;
        if ({out_valid, busy} !== 2'b00 ||
            req0_ready !== (req0_valid && !nxt) || req1_ready !== (req1_valid && nxt)) begin
            n_fail++;
            $display("FAIL %s release: valid=%b busy=%b rdy=%b%b expected valid=0 busy=0 rdy=%b%b",
                     tag, out_valid, busy, req0_ready, req1_ready,
                     req0_valid && !nxt, req1_valid && nxt);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        req0_x = 10'h1FC; req0_y = 10'h1FC; req1_x = 10'h200; req1_y = 10'h004;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: rdy=%b%b expected 00", req0_ready, req1_ready);
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({out_valid, busy, req0_ready, req1_ready, out_id} !== 5'b0 || out_rsq !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b busy=%b rdy=%b%b id=%b rsq=%0d expected all zero",
                     out_valid, busy, req0_ready, req1_ready, out_id, out_rsq);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        m_last = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b busy=%b expected 00", out_valid, busy);
        end
    endtask

    task automatic test_single;
        logic [14:0] r; logic i;
        do_txn("single", 1'b1, 1'b0, 10'h1FC, 10'h1FC, 10'h000, 10'h000, 0, 1'b0, r, i);
        n_checks++;
        if (r !== 15'd504 || i !== 1'b0) begin
            n_fail++;
            $display("FAIL single_value: rsq=%0d id=%b expected rsq=504 id=0", r, i);
        end
    endtask

    task automatic test_fold;
        logic [14:0] r; logic i;
        do_txn("fold", 1'b0, 1'b1, 10'h000, 10'h000, 10'h200, 10'h004, 0, 1'b0, r, i);
        n_checks++;
        if (r !== 15'd252 || i !== 1'b1) begin
            n_fail++;
            $display("FAIL fold_value: rsq=%0d id=%b expected rsq=252 id=1", r, i);
        end
    endtask

    task automatic test_zero;
        logic [14:0] r; logic i;
        do_txn("zero", 1'b1, 1'b0, 10'h000, 10'h003, 10'h000, 10'h000, 0, 1'b0, r, i);
        n_checks++;
        if (r !== 15'd0) begin
            n_fail++;
            $display("FAIL zero_value: rsq=%0d expected 0", r);
        end
    endtask

    // Both requesters valid throughout, result always taken at once.
    task automatic test_tie;
        int acc_cyc[$];
        logic acc_id[$];
        logic res_id[$];
        logic exp_seq [4];
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset(2);
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        req0_x = 10'($urandom); req0_y = 10'($urandom);
        req1_x = 10'($urandom); req1_y = 10'($urandom);
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                acc_cyc.push_back(cyc);
                acc_id.push_back(req1_ready);
            end
            if (out_valid) res_id.push_back(out_id);
            @(negedge clk);
        end
        n_checks++;
        if (acc_cyc.size() < 4 || res_id.size() < 4) begin
            n_fail++;
            $display("FAIL tie_count: accepts=%0d results=%0d expected at least 4 each",
                     acc_cyc.size(), res_id.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (acc_id[k] !== exp_seq[k] || res_id[k] !== exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL tie_order[%0d]: grant=%b out_id=%b expected %b",
                             k, acc_id[k], res_id[k], exp_seq[k]);
                end
                if (k > 0) begin
                    n_checks++;
                    if (acc_cyc[k] - acc_cyc[k-1] !== 4) begin
                        n_fail++;
                        $display("FAIL tie_spacing[%0d]: gap=%0d expected 4",
                                 k, acc_cyc[k] - acc_cyc[k-1]);
                    end
                end
            end
        end
        do_reset(2);
    endtask

    task automatic test_backpressure;
        logic [14:0] r; logic i;
        do_txn("backpressure", 1'b1, 1'b1, 10'($urandom), 10'($urandom),
               10'($urandom), 10'($urandom), 5, 1'b1, r, i);
    endtask

    task automatic test_reset_sqy;
        logic [14:0] r; logic i;
        req0_valid = 1'b1; req0_x = 10'h1FC; req0_y = 10'h1FC;
        req1_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_grant: ready0=%b expected 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({busy, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_in_sqy: busy=%b valid=%b expected busy=1 valid=0", busy, out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({out_valid, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL abort_quiet%0d: valid=%b busy=%b expected 00", c, out_valid, busy);
            end
            @(negedge clk);
        end
        do_txn("after_abort", 1'b1, 1'b1, 10'h200, 10'h004, 10'h1FC, 10'h1FC, 1, 1'b0, r, i);
        n_checks++;
        if (r !== 15'd252 || i !== 1'b0) begin
            n_fail++;
            $display("FAIL after_abort_value: rsq=%0d id=%b expected rsq=252 id=0", r, i);
        end
    endtask

    task automatic test_random;
        logic [14:0] r; logic i;
        logic [1:0] v;
        for (int n = 0; n < 40; n++) begin
            v = 2'($urandom_range(1, 3));
            do_txn("random", v[0], v[1], 10'($urandom), 10'($urandom),
                   10'($urandom), 10'($urandom), int'($urandom_range(0, 3)), 1'b0, r, i);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        m_last = 1'b1;
        test_reset();
        test_single();
        test_fold();
        test_zero();
        test_tie();
        test_backpressure();
        test_reset_sqy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
